prog_sequencer: RTL and testbench

//  Fetch/execute sequencer for the 9-bit single-issue core. Owns the PC and the run/done handshake with the test harness.

---
 rtl/prog_sequencer_if.sv | 38 +++
 rtl/prog_sequencer.sv | 119 +++++++++++
 tb/tb_prog_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/prog_sequencer_if.sv
// Handshake and decoder-facing bus of the fetch/execute sequencer.
// SEQ_SINGLE_STEP_EN adds the step qualifier to the bus.
interface prog_sequencer_if #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
);
  logic             start;
  logic             instr_halt;
  logic             mem_rd;
  logic             pc_jmp_en;
  logic [PC_W-1:0]  jmp_target;
  logic [PC_W-1:0]  pc;
  logic             exec_en;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] cycle_count;
`ifdef SEQ_SINGLE_STEP_EN
  logic             step;

  modport master (
    output start, instr_halt, mem_rd, pc_jmp_en, jmp_target, step,
    input  pc, exec_en, busy, done, cycle_count
  );
  modport slave (
    input  start, instr_halt, mem_rd, pc_jmp_en, jmp_target, step,
    output pc, exec_en, busy, done, cycle_count
  );
`else
  modport master (
    output start, instr_halt, mem_rd, pc_jmp_en, jmp_target,
    input  pc, exec_en, busy, done, cycle_count
  );
  modport slave (
    input  start, instr_halt, mem_rd, pc_jmp_en, jmp_target,
    output pc, exec_en, busy, done, cycle_count
  );
`endif
endinterface

// File: rtl/prog_sequencer.sv
// Fetch/execute sequencer: owns the PC, gates commits, stalls loads, stops on halt/end of program.
// Optional feature macro: SEQ_SINGLE_STEP_EN (RUN advances only on cycles with step=1).
module prog_sequencer #(
  parameter int PC_W     = 10,
  parameter int PROG_LEN = 1024,
  parameter int LD_WAIT  = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  prog_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_DONE} state_t;

  localparam int              WAIT_W     = (LD_WAIT > 0) ? $clog2(LD_WAIT + 1) : 1;
  localparam logic [PC_W-1:0] LAST_PC    = PC_W'(PROG_LEN - 1);
  localparam logic [PC_W:0]   PROG_LEN_X = (PC_W + 1)'(PROG_LEN);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(LD_WAIT);
  localparam logic            LD_STALL   = (LD_WAIT > 0);

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic              exec_en, busy, done;
  logic              step_ok;
  logic [PC_W-1:0]   adv_pc;
  logic              adv_end;

`ifdef SEQ_SINGLE_STEP_EN
  assign step_ok = bus.step;
`else
  assign step_ok = 1'b1;
`endif

  // Where the PC goes when an instruction retires; adv_end means the run stops and pc holds.
  always_comb begin
    adv_pc  = pc_q;
    adv_end = 1'b0;
    if (bus.pc_jmp_en) begin
      if ({1'b0, bus.jmp_target} >= PROG_LEN_X) adv_end = 1'b1;
      else                                       adv_pc  = bus.jmp_target;
    end else if (pc_q == LAST_PC) begin
      adv_end = 1'b1;
    end else begin
      adv_pc = pc_q + PC_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    wait_d  = wait_q;
    cycle_d = cycle_q;
    exec_en = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        done = (state_q == S_DONE);
        if (bus.start) begin
          state_d = S_RUN;
          pc_d    = '0;
          cycle_d = '0;
        end
      end
      S_RUN: begin
        busy    = 1'b1;
        exec_en = step_ok && !(bus.mem_rd && LD_STALL);
        if (step_ok) begin
          if (cycle_q != '1) cycle_d = cycle_q + CNT_W'(1);
          if (bus.instr_halt) begin
            state_d = S_DONE;
          end else if (bus.mem_rd && LD_STALL) begin
            state_d = S_WAIT;
            wait_d  = WAIT_LOAD;
          end else begin
            pc_d = adv_pc;
            if (adv_end) state_d = S_DONE;
          end
        end
      end
      S_WAIT: begin
        busy   = 1'b1;
        wait_d = wait_q - WAIT_W'(1);
        if (cycle_q != '1) cycle_d = cycle_q + CNT_W'(1);
        // The load's single commit lands on the last stall cycle.
        if (wait_q == WAIT_W'(1)) begin
          exec_en = 1'b1;
          pc_d    = adv_pc;
          state_d = adv_end ? S_DONE : S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      wait_q  <= '0;
      cycle_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wait_q  <= wait_d;
      cycle_q <= cycle_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.cycle_count = cycle_q;
  assign bus.exec_en     = exec_en;
  assign bus.busy        = busy;
  assign bus.done        = done;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: DUT A (1024 instrs, 2-cycle load stall), DUT B (8 instrs, 3-bit counter).
// Per-cycle vector tables plus hand-written reset, halt-run and single-step sequences.
module tb_prog_sequencer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  prog_sequencer_if #(.PC_W(10), .CNT_W(16)) a_if ();
  prog_sequencer_if #(.PC_W(4),  .CNT_W(3))  b_if ();

  prog_sequencer #(.PC_W(10), .PROG_LEN(1024), .LD_WAIT(2), .CNT_W(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(a_if.slave)
  );
  prog_sequencer #(.PC_W(4), .PROG_LEN(8), .LD_WAIT(1), .CNT_W(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(b_if.slave)
  );

  typedef struct {
    bit sel;
    bit start, halt, mem, jmp;
    int tgt;
    int pc;
    bit ex, bz, dn;
    int cnt;
  } vec_t;

  vec_t tbl[$];
  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(string name, int act, int exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic drive(bit sel, bit st, bit h, bit m, bit j, int t);
    a_if.start      = sel ? 1'b0 : st;
    a_if.instr_halt = sel ? 1'b0 : h;
    a_if.mem_rd     = sel ? 1'b0 : m;
    a_if.pc_jmp_en  = sel ? 1'b0 : j;
    a_if.jmp_target = sel ? 10'd0 : 10'(t);
    b_if.start      = sel ? st : 1'b0;
    b_if.instr_halt = sel ? h : 1'b0;
    b_if.mem_rd     = sel ? m : 1'b0;
    b_if.pc_jmp_en  = sel ? j : 1'b0;
    b_if.jmp_target = sel ? 4'(t) : 4'd0;
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef SEQ_SINGLE_STEP_EN
    a_if.step = 1'b1;
    b_if.step = 1'b1;
`endif
    drive(0, 0, 0, 0, 0, 0);
    step_clk();
    step_clk();
    reset_n = 1'b1;

    // sel start halt mem jmp tgt | pc ex busy done cnt
    tbl.push_back('{0, 0,0,0,0, 0,     0,    0,0,0, 0});
    tbl.push_back('{0, 1,0,0,0, 0,     0,    0,0,0, 0});
    tbl.push_back('{0, 0,0,0,0, 0,     0,    1,1,0, 0});
    tbl.push_back('{0, 0,0,0,0, 0,     1,    1,1,0, 1});
    tbl.push_back('{0, 0,0,0,0, 0,     2,    1,1,0, 2});
    tbl.push_back('{0, 0,0,1,0, 0,     3,    0,1,0, 3});
    tbl.push_back('{0, 0,0,1,0, 0,     3,    0,1,0, 4});
    tbl.push_back('{0, 0,0,1,0, 0,     3,    1,1,0, 5});
    tbl.push_back('{0, 0,0,0,1, 'h120, 4,    1,1,0, 6});
    tbl.push_back('{0, 0,0,0,0, 0,     'h120,1,1,0, 7});
    tbl.push_back('{0, 0,0,0,1, 1023,  'h121,1,1,0, 8});
    tbl.push_back('{0, 0,0,0,0, 0,     1023, 1,1,0, 9});
    tbl.push_back('{0, 0,0,0,0, 0,     1023, 0,0,1, 10});
    tbl.push_back('{0, 1,0,0,0, 0,     1023, 0,0,1, 10});
    tbl.push_back('{0, 0,0,0,1, 9,     0,    1,1,0, 0});
    tbl.push_back('{0, 0,1,0,1, 'h55,  9,    1,1,0, 1});
    tbl.push_back('{0, 0,0,0,0, 0,     9,    0,0,1, 2});
    tbl.push_back('{1, 1,0,0,0, 0,     0,    0,0,0, 0});
    tbl.push_back('{1, 0,0,0,0, 0,     0,    1,1,0, 0});
    tbl.push_back('{1, 0,0,0,0, 0,     1,    1,1,0, 1});
    tbl.push_back('{1, 0,0,1,0, 0,     2,    0,1,0, 2});
    tbl.push_back('{1, 0,0,1,0, 0,     2,    1,1,0, 3});
    tbl.push_back('{1, 0,0,0,0, 0,     3,    1,1,0, 4});
    tbl.push_back('{1, 0,0,0,0, 0,     4,    1,1,0, 5});
    tbl.push_back('{1, 0,0,0,0, 0,     5,    1,1,0, 6});
    tbl.push_back('{1, 0,0,0,0, 0,     6,    1,1,0, 7});
    tbl.push_back('{1, 0,0,0,0, 0,     7,    1,1,0, 7});
    tbl.push_back('{1, 1,0,0,0, 0,     7,    0,0,1, 7});
    tbl.push_back('{1, 0,0,0,0, 0,     0,    1,1,0, 0});
    tbl.push_back('{1, 0,0,0,0, 0,     1,    1,1,0, 1});
    tbl.push_back('{1, 0,0,0,0, 0,     2,    1,1,0, 2});
    tbl.push_back('{1, 0,0,0,1, 8,     3,    1,1,0, 3});
    tbl.push_back('{1, 0,0,0,0, 0,     3,    0,0,1, 4});
    tbl.push_back('{1, 1,0,0,0, 0,     3,    0,0,1, 4});
    tbl.push_back('{1, 0,0,0,0, 0,     0,    1,1,0, 0});

    foreach (tbl[i]) begin
      vec_t v;
      v = tbl[i];
      drive(v.sel, v.start, v.halt, v.mem, v.jmp, v.tgt);
      @(negedge clk);
      if (v.sel) begin
        check($sformatf("vec%0d_b_pc", i),   int'(b_if.pc),          v.pc);
        check($sformatf("vec%0d_b_exec", i), int'(b_if.exec_en),     int'(v.ex));
        check($sformatf("vec%0d_b_busy", i), int'(b_if.busy),        int'(v.bz));
        check($sformatf("vec%0d_b_done", i), int'(b_if.done),        int'(v.dn));
        check($sformatf("vec%0d_b_cnt", i),  int'(b_if.cycle_count), v.cnt);
      end else begin
        check($sformatf("vec%0d_a_pc", i),   int'(a_if.pc),          v.pc);
        check($sformatf("vec%0d_a_exec", i), int'(a_if.exec_en),     int'(v.ex));
        check($sformatf("vec%0d_a_busy", i), int'(a_if.busy),        int'(v.bz));
        check($sformatf("vec%0d_a_done", i), int'(a_if.done),        int'(v.dn));
        check($sformatf("vec%0d_a_cnt", i),  int'(a_if.cycle_count), v.cnt);
      end
      step_clk();
    end

    // Restart from DONE, five plain instructions then halt at pc=5.
    drive(0, 1, 0, 0, 0, 0);
    step_clk();
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, (i == 5), 0, 0, 0);
      @(negedge clk);
      check($sformatf("run6_pc%0d", i),   int'(a_if.pc),      i);
      check($sformatf("run6_exec%0d", i), int'(a_if.exec_en), 1);
      step_clk();
    end
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("run6_done", int'(a_if.done),        1);
    check("run6_busy", int'(a_if.busy),        0);
    check("run6_pc",   int'(a_if.pc),          5);
    check("run6_cnt",  int'(a_if.cycle_count), 6);
    step_clk();

`ifdef SEQ_SINGLE_STEP_EN
    // Step pulsed every third cycle: one instruction per pulse.
    a_if.step = 1'b0;
    drive(0, 1, 0, 0, 0, 0);
    step_clk();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      a_if.step = ((i % 3) == 2);
      @(negedge clk);
      check($sformatf("step_pc%0d", i),   int'(a_if.pc),      i / 3);
      check($sformatf("step_exec%0d", i), int'(a_if.exec_en), int'((i % 3) == 2));
      step_clk();
    end
    a_if.step = 1'b0;
    @(negedge clk);
    check("step_pc_final",  int'(a_if.pc),          3);
    check("step_cnt_final", int'(a_if.cycle_count), 3);
    a_if.step = 1'b1;
    drive(0, 0, 1, 0, 0, 0);
    step_clk();
    drive(0, 0, 0, 0, 0, 0);
`endif

    // Reset asserted mid-run at pc=37.
    drive(0, 1, 0, 0, 0, 0);
    step_clk();
    drive(0, 0, 0, 0, 0, 0);
    repeat (37) step_clk();
    @(negedge clk);
    check("rst_pre_pc",   int'(a_if.pc),   37);
    check("rst_pre_busy", int'(a_if.busy), 1);
    step_clk();
    // pc is now 38; reset must still clear everything at the next edge.
    reset_n = 1'b0;
    step_clk();
    check("rst_pc",   int'(a_if.pc),          0);
    check("rst_busy", int'(a_if.busy),        0);
    check("rst_done", int'(a_if.done),        0);
    check("rst_exec", int'(a_if.exec_en),     0);
    check("rst_cnt",  int'(a_if.cycle_count), 0);
    step_clk();
    reset_n = 1'b1;
    step_clk();
    check("rst_idle_pc",   int'(a_if.pc),   0);
    check("rst_idle_busy", int'(a_if.busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
